e203_ifu_bjp_sched: RTL and testbench

//  Sequences branch/jump target prediction for IFU instructions that have been mini-decoded.

---
 rtl/e203_ifu_bjp_sched.sv | 156 +++++++++++++++
 tb/tb_e203_ifu_bjp_sched.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_ifu_bjp_sched.sv
// Branch/jump prediction scheduler: resolves jalr rs1 and emits a registered prediction.
// Define E203_IFU_BJP_BTFN_EN to predict backward conditional branches as taken.
module e203_ifu_bjp_sched #(
    parameter int PC_SIZE = 32,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [PC_SIZE-1:0] i_pc,
    input  logic               i_dec_rv32,
    input  logic               i_dec_jal,
    input  logic               i_dec_jalr,
    input  logic               i_dec_bxx,
    input  logic [RFIDX_W-1:0] i_jalr_rs1idx,
    input  logic [PC_SIZE-1:0] i_bjp_imm,
    input  logic               i_flush,
    input  logic               x1_dep,
    input  logic [PC_SIZE-1:0] x1_val,
    input  logic               xn_dep,
    output logic               rf_req,
    output logic [RFIDX_W-1:0] rf_idx,
    input  logic               rf_gnt,
    input  logic [PC_SIZE-1:0] rf_rdata,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [PC_SIZE-1:0] o_pc,
    output logic               o_prdt_taken,
    output logic [PC_SIZE-1:0] o_prdt_pc
);

    typedef enum logic [2:0] {IDLE, X1W, XNW, XNR, XND} state_t;

    state_t             state;
    logic [PC_SIZE-1:0] pc_q;
    logic [PC_SIZE-1:0] imm_q;
    logic [PC_SIZE-1:0] rd_q;
    logic [RFIDX_W-1:0] idx_q;
    logic               rd_held;

    logic               out_free;
    logic               accept;
    logic               is_x0;
    logic               is_x1;
    logic [PC_SIZE-1:0] acc_rs1;
    logic [PC_SIZE-1:0] seq_pc;
    logic [PC_SIZE-1:0] jalr_sum;
    logic               acc_taken;
    logic [PC_SIZE-1:0] acc_tgt;
    logic [PC_SIZE-1:0] late_rs1;
    logic [PC_SIZE-1:0] late_sum;
    logic [PC_SIZE-1:0] late_tgt;

    assign out_free = !o_valid || o_ready;
    assign i_ready  = (state == IDLE) && out_free && !i_flush && !rst;
    assign accept   = i_valid && i_ready;
    assign rf_req   = (state == XNR) && !i_flush;
    assign rf_idx   = idx_q;

    assign is_x0    = (i_jalr_rs1idx == '0);
    assign is_x1    = (i_jalr_rs1idx == RFIDX_W'(1));
    assign acc_rs1  = is_x1 ? x1_val : '0;
    assign seq_pc   = i_pc + (i_dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
    assign jalr_sum = acc_rs1 + i_bjp_imm;

    always_comb begin
        acc_taken = 1'b0;
        acc_tgt   = seq_pc;
        if (i_dec_jalr) begin
            acc_taken = 1'b1;
            acc_tgt   = {jalr_sum[PC_SIZE-1:1], 1'b0};
        end else if (i_dec_jal) begin
            acc_taken = 1'b1;
            acc_tgt   = i_pc + i_bjp_imm;
        end
`ifdef E203_IFU_BJP_BTFN_EN
        else if (i_dec_bxx && i_bjp_imm[PC_SIZE-1]) begin
            acc_taken = 1'b1;
            acc_tgt   = i_pc + i_bjp_imm;
        end
`endif
    end

`ifndef E203_IFU_BJP_BTFN_EN
    logic unused_bxx;
    assign unused_bxx = i_dec_bxx;
`endif

    // Read data is only on the bus the cycle after grant; keep it if the output stalls.
    assign late_rs1 = (state == X1W) ? x1_val : (rd_held ? rd_q : rf_rdata);
    assign late_sum = late_rs1 + imm_q;
    assign late_tgt = {late_sum[PC_SIZE-1:1], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_prdt_taken <= 1'b0;
            o_prdt_pc    <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            idx_q        <= '0;
            rd_held      <= 1'b0;
        end else if (i_flush) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            rd_held <= 1'b0;
        end else begin
            if (o_valid && o_ready) o_valid <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    pc_q  <= i_pc;
                    imm_q <= i_bjp_imm;
                    idx_q <= i_jalr_rs1idx;
                    if (i_dec_jalr && is_x1 && x1_dep) begin
                        state <= X1W;
                    end else if (i_dec_jalr && !is_x0 && !is_x1) begin
                        state <= XNW;
                    end else begin
                        o_valid      <= 1'b1;
                        o_pc         <= i_pc;
                        o_prdt_taken <= acc_taken;
                        o_prdt_pc    <= acc_tgt;
                    end
                end
                X1W: if (!x1_dep && out_free) begin
                    o_valid      <= 1'b1;
                    o_pc         <= pc_q;
                    o_prdt_taken <= 1'b1;
                    o_prdt_pc    <= late_tgt;
                    state        <= IDLE;
                end
                XNW: if (!xn_dep) state <= XNR;
                XNR: if (rf_gnt) state <= XND;
                XND: begin
                    if (out_free) begin
                        o_valid      <= 1'b1;
                        o_pc         <= pc_q;
                        o_prdt_taken <= 1'b1;
                        o_prdt_pc    <= late_tgt;
                        rd_held      <= 1'b0;
                        state        <= IDLE;
                    end else if (!rd_held) begin
                        rd_q    <= rf_rdata;
                        rd_held <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_ifu_bjp_sched.sv
// Self-checking bench for e203_ifu_bjp_sched: directed scenarios plus a
// randomized run scored against a queue-based prediction model.
module tb_e203_ifu_bjp_sched;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } pred_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_pc;
    logic        i_dec_rv32;
    logic        i_dec_jal;
    logic        i_dec_jalr;
    logic        i_dec_bxx;
    logic [4:0]  i_jalr_rs1idx;
    logic [31:0] i_bjp_imm;
    logic        i_flush;
    logic        x1_dep;
    logic [31:0] x1_val;
    logic        xn_dep;
    logic        rf_req;
    logic [4:0]  rf_idx;
    logic        rf_gnt;
    logic [31:0] rf_rdata;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_pc;
    logic        o_prdt_taken;
    logic [31:0] o_prdt_pc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] regs [32];
    bit          btfn;

    always #5 clk = ~clk;

    e203_ifu_bjp_sched #(.PC_SIZE(32), .RFIDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_pc(i_pc),
        .i_dec_rv32(i_dec_rv32), .i_dec_jal(i_dec_jal),
        .i_dec_jalr(i_dec_jalr), .i_dec_bxx(i_dec_bxx),
        .i_jalr_rs1idx(i_jalr_rs1idx), .i_bjp_imm(i_bjp_imm),
        .i_flush(i_flush), .x1_dep(x1_dep), .x1_val(x1_val),
        .xn_dep(xn_dep), .rf_req(rf_req), .rf_idx(rf_idx),
        .rf_gnt(rf_gnt), .rf_rdata(rf_rdata),
        .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc),
        .o_prdt_taken(o_prdt_taken), .o_prdt_pc(o_prdt_pc)
    );

    // typ: 0 jal, 1 jalr, 2 bxx, 3 other
    function automatic pred_t predict(input int typ, input logic [31:0] pc,
                                      input logic [31:0] imm, input bit rv32,
                                      input logic [4:0] rs1);
        pred_t p;
        logic [31:0] v;
        logic [31:0] s;
        p.pc    = pc;
        p.taken = 1'b0;
        p.tgt   = pc + (rv32 ? 32'd4 : 32'd2);
        if (typ == 0) begin
            p.taken = 1'b1;
            p.tgt   = pc + imm;
        end else if (typ == 1) begin
            v = (rs1 == 0) ? 32'd0 : (rs1 == 1) ? x1_val : regs[rs1];
            s = v + imm;
            p.taken = 1'b1;
            p.tgt   = {s[31:1], 1'b0};
        end else if (typ == 2 && btfn && $signed(imm) < 0) begin
            p.taken = 1'b1;
            p.tgt   = pc + imm;
        end
        return p;
    endfunction

    task automatic clear_inputs();
        i_valid = 0; i_pc = 0; i_dec_rv32 = 1; i_dec_jal = 0;
        i_dec_jalr = 0; i_dec_bxx = 0; i_jalr_rs1idx = 0;
        i_bjp_imm = 0; i_flush = 0; x1_dep = 0; xn_dep = 0;
        rf_gnt = 0; rf_rdata = 0; o_ready = 1;
    endtask

    task automatic drive(input int typ, input logic [31:0] pc,
                         input logic [31:0] imm, input bit rv32,
                         input logic [4:0] rs1);
        i_valid = 1; i_pc = pc; i_bjp_imm = imm; i_dec_rv32 = rv32;
        i_jalr_rs1idx = rs1;
        i_dec_jal = (typ == 0); i_dec_jalr = (typ == 1);
        i_dec_bxx = (typ == 2);
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({o_valid, rf_req, o_prdt_taken, i_ready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b req=%b t=%b rdy=%b want 0000",
                     o_valid, rf_req, o_prdt_taken, i_ready);
        end
        checks++;
        if ({o_pc, o_prdt_pc} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got pc=%h tgt=%h want 0", o_pc, o_prdt_pc);
        end
        @(negedge clk); rst = 0; #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", i_ready);
        end
    endtask

    task automatic test_jal();
        @(negedge clk); drive(0, 32'h100, 32'h20, 1, 0); #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++; $display("FAIL jal_ready: got %b want 1", i_ready);
        end
        @(negedge clk); i_valid = 0; #1;
        checks++;
        if ({o_valid, o_prdt_taken, o_pc, o_prdt_pc} !== {2'b11, 32'h100, 32'h120}) begin
            errors++;
            $display("FAIL jal_out: got v=%b t=%b pc=%h tgt=%h want 1 1 100 120",
                     o_valid, o_prdt_taken, o_pc, o_prdt_pc);
        end
        @(negedge clk); #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL jal_drain: got %b want 0", o_valid);
        end
    endtask

    task automatic test_jalr_x1();
        @(negedge clk);
        x1_dep = 1; x1_val = 32'h2001;
        drive(1, 32'h200, 32'h4, 1, 1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            i_valid = 0;
            x1_dep  = (n < 3);
            #1;
            checks++;
            if (n < 4 && {o_valid, i_ready} !== 2'b00) begin
                errors++;
                $display("FAIL x1_wait[%0d]: got v=%b rdy=%b want 0 0", n, o_valid, i_ready);
            end else if (n == 4 && {o_valid, o_prdt_taken, o_pc, o_prdt_pc} !==
                         {2'b11, 32'h200, 32'h2004}) begin
                errors++;
                $display("FAIL x1_out: got v=%b t=%b pc=%h tgt=%h want 1 1 200 2004",
                         o_valid, o_prdt_taken, o_pc, o_prdt_pc);
            end
        end
    endtask

    task automatic run_xn(input bit flush);
        @(negedge clk);
        xn_dep = 1; drive(1, 32'h300, 32'hFFFF_FFF8, 1, 5);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            i_valid  = 0;
            xn_dep   = (n < 2);
            rf_gnt   = (n == 1) || (n == 5);
            i_flush  = flush && (n == 5);
            rf_rdata = (n == 6) ? 32'h3000 : 32'hDEAD_BEEF;
            #1;
            checks++;
            if (n <= 2 && {rf_req, i_ready} !== 2'b00) begin
                errors++;
                $display("FAIL xn_wait[%0d]: got req=%b rdy=%b want 0 0", n, rf_req, i_ready);
            end else if (n >= 3 && n <= 4 && {rf_req, rf_idx, i_ready} !== {1'b1, 5'd5, 1'b0}) begin
                errors++;
                $display("FAIL xn_req[%0d]: got req=%b idx=%0d rdy=%b want 1 5 0",
                         n, rf_req, rf_idx, i_ready);
            end else if (n == 5 && rf_req !== !flush) begin
                errors++;
                $display("FAIL xn_gnt_req: got %b want %b", rf_req, !flush);
            end else if (n == 6 && {rf_req, o_valid, i_ready} !== {2'b00, flush}) begin
                errors++;
                $display("FAIL xn_after_gnt: got req=%b v=%b rdy=%b want 0 0 %b",
                         rf_req, o_valid, i_ready, flush);
            end
        end
        i_flush = 0; rf_gnt = 0;
    endtask

    task automatic test_jalr_xn();
        run_xn(0);
        @(negedge clk); #1;
        checks++;
        if ({o_valid, o_prdt_taken, o_pc, o_prdt_pc} !== {2'b11, 32'h300, 32'h2FF8}) begin
            errors++;
            $display("FAIL xn_out: got v=%b t=%b pc=%h tgt=%h want 1 1 300 2ff8",
                     o_valid, o_prdt_taken, o_pc, o_prdt_pc);
        end
    endtask

    task automatic test_flush();
        run_xn(1);
        drive(0, 32'h500, 32'h10, 1, 0);
        @(negedge clk); i_valid = 0; #1;
        checks++;
        if ({o_valid, o_prdt_taken, o_pc, o_prdt_pc} !== {2'b11, 32'h500, 32'h510}) begin
            errors++;
            $display("FAIL flush_next_jal: got v=%b t=%b pc=%h tgt=%h want 1 1 500 510",
                     o_valid, o_prdt_taken, o_pc, o_prdt_pc);
        end
    endtask

    task automatic test_bxx();
        int          typ [5] = '{2, 3, 2, 0, 3};
        logic [31:0] pc  [5] = '{32'h400, 32'h400, 32'h400, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
        logic [31:0] imm [5] = '{32'hFFFF_FFF0, 32'h0, 32'h40, 32'h20, 32'h0};
        bit          rv  [5] = '{1, 0, 0, 1, 0};
        pred_t       e   [5];
        e[0] = btfn ? '{32'h400, 1'b1, 32'h3F0} : '{32'h400, 1'b0, 32'h404};
        e[1] = '{32'h400, 1'b0, 32'h402};
        e[2] = '{32'h400, 1'b0, 32'h402};
        e[3] = '{32'hFFFF_FFF0, 1'b1, 32'h10};
        e[4] = '{32'hFFFF_FFFF, 1'b0, 32'h1};
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) drive(typ[k], pc[k], imm[k], rv[k], 0);
            else i_valid = 0;
            #1;
            if (k > 0) begin
                checks++;
                if ({o_valid, o_pc, o_prdt_taken, o_prdt_pc} !== {1'b1, e[k-1]}) begin
                    errors++;
                    $display("FAIL bxx_tbl[%0d]: got v=%b pc=%h t=%b tgt=%h want pc=%h t=%b tgt=%h",
                             k - 1, o_valid, o_pc, o_prdt_taken, o_prdt_pc,
                             e[k-1].pc, e[k-1].taken, e[k-1].tgt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); o_ready = 0; drive(0, 32'h600, 32'h8, 1, 0);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) drive(0, 32'h700, 32'h100, 1, 0);
            if (n == 3) o_ready = 1;
            if (n == 4) i_valid = 0;
            #1;
            checks++;
            if (n <= 2 && {i_ready, o_valid, o_pc, o_prdt_pc} !== {2'b01, 32'h600, 32'h608}) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: got rdy=%b v=%b pc=%h tgt=%h want 0 1 600 608",
                         n, i_ready, o_valid, o_pc, o_prdt_pc);
            end else if (n == 3 && i_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready: got %b want 1", i_ready);
            end else if (n == 4 && {o_valid, o_pc, o_prdt_pc} !== {1'b1, 32'h700, 32'h800}) begin
                errors++;
                $display("FAIL b2b_second: got v=%b pc=%h tgt=%h want 1 700 800",
                         o_valid, o_pc, o_prdt_pc);
            end else if (n == 5 && o_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_drain: got %b want 0", o_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive(1, 32'h900, 32'h0, 1, 7);
        @(negedge clk); i_valid = 0;
        @(negedge clk); #1;
        checks++;
        if ({rf_req, rf_idx} !== {1'b1, 5'd7}) begin
            errors++; $display("FAIL rmid_req: got req=%b idx=%0d want 1 7", rf_req, rf_idx);
        end
        rst = 1;
        @(negedge clk); #1;
        checks++;
        if ({rf_req, o_valid, i_ready, o_prdt_taken, o_pc, o_prdt_pc} !== 68'd0) begin
            errors++;
            $display("FAIL rmid_state: got req=%b v=%b rdy=%b t=%b pc=%h tgt=%h want all 0",
                     rf_req, o_valid, i_ready, o_prdt_taken, o_pc, o_prdt_pc);
        end
        rst = 0;
        @(negedge clk); #1;
        checks++;
        if ({i_ready, rf_req} !== 2'b10) begin
            errors++; $display("FAIL rmid_release: got rdy=%b req=%b want 1 0", i_ready, rf_req);
        end
    endtask

    task automatic test_random();
        pred_t      q[$];
        pred_t      e;
        pred_t      prev;
        bit         prev_hold = 0;
        bit         have = 0;
        bit         gnt_last = 0;
        bit         done = 0;
        logic [4:0] idx_last = 0;
        logic [4:0] inflight = 0;
        logic [4:0] rs1;
        int         typ;
        int         issued = 0;
        x1_val = $urandom;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            rf_rdata = gnt_last ? regs[idx_last] : $urandom;
            x1_dep   = ($urandom_range(0, 9) < 4);
            xn_dep   = ($urandom_range(0, 9) < 4);
            o_ready  = ($urandom_range(0, 3) != 0);
            rf_gnt   = ($urandom_range(0, 2) == 0);
            if (!have && issued < 300 && $urandom_range(0, 3) != 0) begin
                typ = $urandom_range(0, 3);
                case ($urandom_range(0, 2))
                    0: rs1 = 0;
                    1: rs1 = 1;
                    default: rs1 = 5'($urandom_range(2, 31));
                endcase
                drive(typ, $urandom, ($urandom_range(0, 1) != 0) ? $urandom
                      : 32'($signed($urandom_range(0, 255)) - 128), $urandom_range(0, 1), rs1);
                e = predict(typ, i_pc, i_bjp_imm, i_dec_rv32, rs1);
                have = 1;
            end
            i_valid = have;
            #1;
            if (prev_hold) begin
                checks++;
                if ({o_valid, o_pc, o_prdt_taken, o_prdt_pc} !== {1'b1, prev}) begin
                    errors++;
                    $display("FAIL rand_hold: got v=%b pc=%h t=%b tgt=%h want 1 %h %b %h",
                             o_valid, o_pc, o_prdt_taken, o_prdt_pc, prev.pc, prev.taken, prev.tgt);
                end
            end
            if (rf_req) begin
                checks++;
                if (rf_idx !== inflight) begin
                    errors++; $display("FAIL rand_rf_idx: got %0d want %0d", rf_idx, inflight);
                end
            end
            if (o_valid && o_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got pc=%h want no output", o_pc);
                end else begin
                    prev = q.pop_front();
                    if ({o_pc, o_prdt_taken, o_prdt_pc} !== prev) begin
                        errors++;
                        $display("FAIL rand_out: got pc=%h t=%b tgt=%h want pc=%h t=%b tgt=%h",
                                 o_pc, o_prdt_taken, o_prdt_pc, prev.pc, prev.taken, prev.tgt);
                    end
                end
            end
            if (i_valid && i_ready) begin
                q.push_back(e);
                inflight = i_jalr_rs1idx;
                have = 0;
                issued++;
            end
            prev_hold = o_valid && !o_ready;
            prev      = '{o_pc, o_prdt_taken, o_prdt_pc};
            gnt_last  = rf_gnt && rf_req;
            idx_last  = rf_idx;
            done      = (issued >= 300) && (q.size() == 0) && !have;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rand_timeout: got issued=%0d pending=%0d want 300 0", issued, q.size());
        end
        @(negedge clk); clear_inputs();
    endtask

    initial begin
`ifdef E203_IFU_BJP_BTFN_EN
        btfn = 1;
`else
        btfn = 0;
`endif
        regs[0] = 0;
        for (int r = 1; r < 32; r++) regs[r] = $urandom;
        x1_val = 0;
        test_reset();
        test_jal();
        test_jalr_x1();
        test_jalr_xn();
        test_flush();
        test_bxx();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
